// File: rtl/dvi_decoder.sv
// TMDS receive decoder: turns three word-aligned 10-bit symbol streams into RGB, DE and syncs,
// regenerates pixel coordinates and tracks frame geometry to report lock.
//
// state  | meaning
// SEARCH | no reference vsync yet; waiting for the first vsync rising edge
// ARM    | measuring one full frame between vsync edges before trusting it
// LOCKED | geometry confirmed; end markers active, mismatches drop back to SEARCH
module dvi_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter bit SYNC_INVERT = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        n_reset,
    input  logic [9:0]  tmds_r,
    input  logic [9:0]  tmds_g,
    input  logic [9:0]  tmds_b,
    output logic [23:0] rgb_data,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        line_end,
    output logic        frame_end,
    output logic        locked,
    output logic        symbol_err,
    output logic        geom_err
);

    typedef enum logic [1:0] {SEARCH, ARM, LOCKED} state_t;

    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] V_CNT  = 11'(V_ACTIVE);

    function automatic logic is_token(input logic [9:0] q);
        return q inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
    endfunction

    function automatic logic [1:0] token_c(input logic [9:0] q);
        case (q)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] v;
        logic [7:0] d;
        v    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    state_t      state, state_nxt;
    logic [10:0] line_cnt;
    logic        width_ok;
    logic        first_line;

    logic        tok_r, tok_g, tok_b;
    logic        all_data, all_tok, mixed;
    logic [1:0]  c_b;
    logic        hs_nxt, vs_nxt;
    logic        vs_rise, de_rise, de_fall;
    logic        width_bad, height_bad;
    logic [9:0]  xpos_nxt, ypos_nxt;
    logic        geom_err_nxt;

    assign tok_r    = is_token(tmds_r);
    assign tok_g    = is_token(tmds_g);
    assign tok_b    = is_token(tmds_b);
    assign all_data = ~(tok_r | tok_g | tok_b);
    assign all_tok  = tok_r & tok_g & tok_b;
    assign mixed    = ~all_data & ~all_tok;
    assign c_b      = token_c(tmds_b);

    // Syncs only follow the blue token; data and illegal symbols leave them untouched.
    assign hs_nxt = all_tok ? (c_b[0] ^ SYNC_INVERT) : hsync;
    assign vs_nxt = all_tok ? (c_b[1] ^ SYNC_INVERT) : vsync;

    assign vs_rise    = vs_nxt & ~vsync;
    assign de_rise    = all_data & ~de;
    assign de_fall    = de & ~all_data;
    assign width_bad  = de_fall && (xpos != X_LAST);
    assign height_bad = vs_rise && (line_cnt != V_CNT);

    always_comb begin
        xpos_nxt = xpos;
        ypos_nxt = ypos;
        if (de_rise) begin
            xpos_nxt = '0;
            ypos_nxt = first_line ? '0 : ((ypos != 10'h3FF) ? ypos + 10'd1 : ypos);
        end else if (all_data && xpos != 10'h3FF) begin
            xpos_nxt = xpos + 10'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        geom_err_nxt = 1'b0;
        case (state)
            SEARCH: if (vs_rise) state_nxt = ARM;
            ARM: begin
                if (mixed)
                    state_nxt = SEARCH;
                else if (vs_rise && width_ok && !width_bad && !height_bad)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (width_bad || height_bad) begin
                    state_nxt    = SEARCH;
                    geom_err_nxt = 1'b1;
                end else if (mixed) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge n_reset) begin
        if (!n_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk_pixel or negedge n_reset) begin
        if (!n_reset) begin
            rgb_data   <= '0;
            de         <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            xpos       <= '0;
            ypos       <= '0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            symbol_err <= 1'b0;
            geom_err   <= 1'b0;
            line_cnt   <= '0;
            width_ok   <= 1'b1;
            first_line <= 1'b1;
        end else begin
            rgb_data   <= all_data ? {tmds_decode(tmds_r), tmds_decode(tmds_g), tmds_decode(tmds_b)} : 24'd0;
            de         <= all_data;
            hsync      <= hs_nxt;
            vsync      <= vs_nxt;
            xpos       <= xpos_nxt;
            ypos       <= ypos_nxt;
            line_end   <= (state == LOCKED) && all_data && (xpos_nxt == X_LAST) && (ypos_nxt < Y_LAST);
            frame_end  <= (state == LOCKED) && all_data && (xpos_nxt == X_LAST) && (ypos_nxt == Y_LAST);
            symbol_err <= mixed;
            geom_err   <= geom_err_nxt;
            // Counts restart at every vsync rising edge so each interval is judged on its own.
            if (vs_rise)
                line_cnt <= '0;
            else if (de_rise && line_cnt != 11'h7FF)
                line_cnt <= line_cnt + 11'd1;
            if (vs_rise)
                width_ok <= 1'b1;
            else if (width_bad)
                width_ok <= 1'b0;
            if (vs_rise)
                first_line <= 1'b1;
            else if (de_rise)
                first_line <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dvi_decoder.sv
// Directed bench for dvi_decoder using a reduced 16x6 active / 24x10 total raster.
module tb_dvi_decoder;

    localparam int H     = 16;
    localparam int V     = 6;
    localparam int H_TOT = 24;
    localparam int V_TOT = 10;
    localparam int HS0 = 18, HS1 = 19;
    localparam int VS0 = 7,  VS1 = 8;

    logic        clk_pixel = 1'b0;
    logic        n_reset   = 1'b0;
    logic [9:0]  tmds_r = 10'h354, tmds_g = 10'h354, tmds_b = 10'h2AB;
    logic [23:0] rgb_data;
    logic        de, hsync, vsync;
    logic [9:0]  xpos, ypos;
    logic        line_end, frame_end, locked, symbol_err, geom_err;

    int n_checks = 0;
    int n_pass   = 0;

    dvi_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_INVERT(1'b1)) dut (
        .clk_pixel(clk_pixel), .n_reset(n_reset),
        .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b),
        .rgb_data(rgb_data), .de(de), .hsync(hsync), .vsync(vsync),
        .xpos(xpos), .ypos(ypos), .line_end(line_end), .frame_end(frame_end),
        .locked(locked), .symbol_err(symbol_err), .geom_err(geom_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // XOR-mode encoder; falls back to the inverted form when the word would alias a control token.
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [7:0] v;
        logic [9:0] q;
        v[0] = d[0];
        for (int i = 1; i < 8; i++) v[i] = v[i-1] ^ d[i];
        q = {2'b01, v};
        if (q == 10'h154) q = {2'b11, ~v};
        return q;
    endfunction

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [23:0] pix(input int x, input int y);
        return {8'(x * 13 + y), 8'((y * 29) ^ x), 8'(x + 7 * y + 85)};
    endfunction

    task automatic send(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        tmds_r = r;
        tmds_g = g;
        tmds_b = b;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic send_pixel(input int x, input int y, input int short_y, output logic active);
        logic [23:0] p;
        logic        hs, vs;
        active = (y < V) && (x < ((y == short_y) ? H - 1 : H));
        if (active) begin
            p = pix(x, y);
            send(enc(p[23:16]), enc(p[15:8]), enc(p[7:0]));
        end else begin
            hs = (x >= HS0) && (x <= HS1);
            vs = (y >= VS0) && (y <= VS1);
            // Blue carries the (inverted) syncs; R/G carry arbitrary tokens that must be ignored.
            send(10'h0AB, 10'h154, tok({~vs, ~hs}));
        end
    endtask

    task automatic send_frame(input int short_y, input bit check_pos,
                              output int n_le, output int n_fe, output int n_ge,
                              output int n_se, output int n_bad);
        logic active;
        n_le = 0; n_fe = 0; n_ge = 0; n_se = 0; n_bad = 0;
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                send_pixel(x, y, short_y, active);
                if (active) begin
                    if (de !== 1'b1 || rgb_data !== pix(x, y)) n_bad++;
                    if (check_pos && (xpos !== 10'(x) || ypos !== 10'(y))) n_bad++;
                end else begin
                    if (de !== 1'b0 || rgb_data !== 24'd0) n_bad++;
                end
                if (line_end === 1'b1)   n_le++;
                if (geom_err === 1'b1)   n_ge++;
                if (symbol_err === 1'b1) n_se++;
                if (frame_end === 1'b1) begin
                    n_fe++;
                    check("frame_end_xpos", 32'(xpos), 32'(H - 1));
                    check("frame_end_ypos", 32'(ypos), 32'(V - 1));
                end
                if (y == short_y && x == H - 1) check("geom_err_short_line", 32'(geom_err), 32'd1);
                if (y == short_y && x == H)     check("locked_after_short", 32'(locked), 32'd0);
            end
        end
    endtask

    initial begin
        int   le, fe, ge, se, bad;
        logic act;

        #1;
        check("rst_rgb", 32'(rgb_data), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_sync", 32'({hsync, vsync}), 32'd0);
        check("rst_pos", 32'({xpos, ypos}), 32'd0);
        check("rst_flags", 32'({line_end, frame_end, locked, symbol_err, geom_err}), 32'd0);
        repeat (2) @(posedge clk_pixel);
        #1 n_reset = 1'b1;

        send(10'h200, 10'h200, 10'h200);
        check("rgb_0x200", 32'(rgb_data), 32'hFFFFFF);
        check("de_data", 32'(de), 32'd1);
        send(10'h100, 10'h100, 10'h100);
        check("rgb_0x100", 32'(rgb_data), 32'h000000);
        send(10'h1AA, 10'h055, 10'h2F0);
        check("rgb_mixed_modes", 32'(rgb_data), 32'hFE01EF);
        send(10'h354, 10'h354, 10'h2AB);
        check("ctrl_de_rgb", 32'({de, rgb_data}), 32'd0);
        check("ctrl_sync_idle", 32'({hsync, vsync}), 32'd0);
        send(10'h354, 10'h354, 10'h354);
        check("ctrl_sync_active", 32'({hsync, vsync}), 32'b11);
        send(10'h354, 10'h200, 10'h200);
        check("mixed_symbol_err", 32'(symbol_err), 32'd1);
        check("mixed_rgb_de", 32'({de, rgb_data}), 32'd0);
        check("mixed_sync_hold", 32'({hsync, vsync}), 32'b11);
        send(10'h354, 10'h354, 10'h2AB);
        check("symbol_err_one_cycle", 32'(symbol_err), 32'd0);
        check("sync_release", 32'({hsync, vsync}), 32'd0);

        n_reset = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1 n_reset = 1'b1;

        send_frame(-1, 1'b0, le, fe, ge, se, bad);
        check("frameA_locked", 32'(locked), 32'd0);
        check("frameA_data", 32'(bad), 32'd0);
        check("frameA_errs", 32'(ge + se), 32'd0);
        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        check("frameB_locked", 32'(locked), 32'd1);
        check("frameB_data_pos", 32'(bad), 32'd0);
        check("frameB_line_end", 32'(le), 32'd0);
        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        check("frameC_line_end", 32'(le), 32'(V - 1));
        check("frameC_frame_end", 32'(fe), 32'd1);
        check("frameC_errs", 32'(ge + se), 32'd0);
        check("frameC_locked", 32'(locked), 32'd1);
        check("frameC_data_pos", 32'(bad), 32'd0);

        send_frame(2, 1'b1, le, fe, ge, se, bad);
        check("frameD_geom_pulses", 32'(ge), 32'd1);
        check("frameD_locked", 32'(locked), 32'd0);
        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        check("frameE_relock", 32'(locked), 32'd1);
        check("frameE_errs", 32'(ge + se), 32'd0);

        for (int y = 0; y < 3; y++)
            for (int x = 0; x < ((y == 2) ? 5 : H_TOT); x++)
                send_pixel(x, y, -1, act);
        check("pre_reset_locked_de", 32'({locked, de}), 32'b11);
        n_reset = 1'b0;
        #1;
        check("async_rst_rgb_de", 32'({de, rgb_data}), 32'd0);
        check("async_rst_pos", 32'({xpos, ypos}), 32'd0);
        check("async_rst_flags", 32'({hsync, vsync, locked, line_end, frame_end, symbol_err, geom_err}), 32'd0);
        repeat (2) @(posedge clk_pixel);
        #1 n_reset = 1'b1;

        send_frame(-1, 1'b0, le, fe, ge, se, bad);
        check("frameG_locked", 32'(locked), 32'd0);
        check("frameG_errs", 32'(ge + se), 32'd0);
        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        check("frameH_locked", 32'(locked), 32'd1);

        send(10'h354, 10'h200, 10'h100);
        check("locked_symbol_err", 32'(symbol_err), 32'd1);
        check("locked_symbol_rgb", 32'(rgb_data), 32'd0);
        send(10'h354, 10'h354, 10'h2AB);
        check("symbol_err_unlock", 32'(locked), 32'd0);
        check("symbol_err_no_geom", 32'(geom_err), 32'd0);

        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        send_frame(-1, 1'b1, le, fe, ge, se, bad);
        check("frameJ_locked", 32'(locked), 32'd1);

        for (int x = 0; x < 10; x++) send(enc(8'(x)), enc(8'(x + 1)), enc(8'(x + 2)));
        send(10'h0AB, 10'h154, 10'h0AB);
        check("simul_geom_err", 32'(geom_err), 32'd1);
        check("simul_vsync", 32'(vsync), 32'd1);
        check("simul_unlock", 32'(locked), 32'd0);
        send(10'h0AB, 10'h154, 10'h0AB);
        check("simul_single_pulse", 32'(geom_err), 32'd0);
        send(10'h354, 10'h354, 10'h2AB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
